// File: rtl/conv_pkg.sv
// Shared constants and types for the conv_2d correlation engine.
package conv_pkg;

    localparam int DW     = 8;
    localparam int OW     = 16;
    localparam int MAX_IN = 8;
    localparam int MAX_K  = 4;

    typedef enum logic [2:0] {
        LOAD_IN,
        LOAD_K,
        GAP,
        COMPUTE,
        OUT
    } phase_t;

    typedef logic [3:0] dim_t;

endpackage

// File: rtl/conv_2d_if.sv
// Data/dimension bundle between the stream source/sink and conv_2d.
interface conv_2d_if #(
    parameter int DW = conv_pkg::DW,
    parameter int OW = conv_pkg::OW
);
    import conv_pkg::*;

    logic [DW-1:0] inMatrix;
    dim_t          inRow;
    dim_t          inCol;
    logic [DW-1:0] kernel;
    dim_t          kerRow;
    dim_t          kerCol;
    logic [OW-1:0] outMatrix;

    modport master (
        output inMatrix, inRow, inCol, kernel, kerRow, kerCol,
        input  outMatrix
    );

    modport slave (
        input  inMatrix, inRow, inCol, kernel, kerRow, kerCol,
        output outMatrix
    );

endinterface

// File: rtl/conv_mac.sv
// Unsigned multiply-accumulate; clear has priority over enable, sum wraps at OW bits.
module conv_mac #(
    parameter int DW = 8,
    parameter int OW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [OW-1:0] acc
);

    logic [2*DW-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + OW'(prod);
        end
    end

endmodule

// File: rtl/conv_2d.sv
// Self-sequenced valid-mode 2-D correlation: load input, load kernel, MAC every
// output position, then stream results; phase lengths follow the latched dimensions.
module conv_2d
    import conv_pkg::*;
#(
    parameter int DW     = conv_pkg::DW,
    parameter int OW     = conv_pkg::OW,
    parameter int MAX_IN = conv_pkg::MAX_IN,
    parameter int MAX_K  = conv_pkg::MAX_K
) (
    input logic       clk,
    input logic       rst,
    conv_2d_if.slave  bus
);

    localparam int IA = $clog2(MAX_IN * MAX_IN);
    localparam int KA = $clog2(MAX_K * MAX_K);

    phase_t phase, phase_nx;
    logic   first;
    dim_t   r_q, c_q, kr_q, kc_q;
    dim_t   r, c, ro, co;
    dim_t   row, col, i, j, ka, kb;
    logic [IA-1:0] pos, last_pos;
    logic   legal;
    logic   row_end, load_in_end, load_k_end, gap_end;
    logic   k_row_end, pos_end, comp_end, out_end;
    logic   wr_in, wr_k, mac_en, mac_clr;
    logic [IA-1:0] wr_in_addr, rd_in_addr;
    logic [KA-1:0] wr_k_addr, rd_k_addr;
    logic [DW-1:0] mac_a, mac_b;
    logic [OW-1:0] acc;

    logic [DW-1:0] in_buf  [MAX_IN*MAX_IN];
    logic [DW-1:0] k_buf   [MAX_K*MAX_K];
    logic [OW-1:0] res_buf [MAX_IN*MAX_IN];

    // On the first LOAD_IN beat the row length must come straight from the ports,
    // since the latched copy only becomes valid after that edge.
    always_comb begin
        r = first ? bus.inRow : r_q;
        c = first ? bus.inCol : c_q;
        ro = r_q - kr_q + 4'd1;
        co = c_q - kc_q + 4'd1;
        legal = (kr_q != 4'd0) && (kc_q != 4'd0) && (kr_q <= r_q) && (kc_q <= c_q)
             && (int'(r_q) <= MAX_IN) && (int'(c_q) <= MAX_IN)
             && (int'(kr_q) <= MAX_K) && (int'(kc_q) <= MAX_K);
        last_pos = IA'(int'(ro) * int'(co) - 1);

        row_end     = (col == c);
        load_in_end = row_end && (row == r - 4'd1);
        load_k_end  = (col == kc_q) && (row == kr_q - 4'd1);
        gap_end     = (col == 4'd1);
        k_row_end   = (kb == kc_q);
        pos_end     = k_row_end && (ka == kr_q - 4'd1);
        comp_end    = pos_end && (i == ro - 4'd1) && (j == co - 4'd1);
        out_end     = (pos == last_pos);

        wr_in = (phase == LOAD_IN) && (col < c) && (int'(row) < MAX_IN) && (int'(col) < MAX_IN);
        wr_k  = (phase == LOAD_K) && (col < kc_q) && (int'(row) < MAX_K) && (int'(col) < MAX_K);
        wr_in_addr = IA'(int'(row) * MAX_IN + int'(col));
        wr_k_addr  = KA'(int'(row) * MAX_K + int'(col));
        rd_in_addr = IA'((int'(i) + int'(ka)) * MAX_IN + int'(j) + int'(kb));
        rd_k_addr  = KA'(int'(ka) * MAX_K + int'(kb));
        mac_a = in_buf[rd_in_addr];
        mac_b = k_buf[rd_k_addr];
        mac_en  = (phase == COMPUTE) && !k_row_end;
        mac_clr = (phase == GAP) || ((phase == COMPUTE) && pos_end);
    end

    always_comb begin
        phase_nx = phase;
        case (phase)
            LOAD_IN: if (load_in_end) phase_nx = LOAD_K;
            LOAD_K:  if (load_k_end)  phase_nx = GAP;
            GAP:     if (gap_end)     phase_nx = legal ? COMPUTE : LOAD_IN;
            COMPUTE: if (comp_end)    phase_nx = OUT;
            OUT:     if (out_end)     phase_nx = LOAD_IN;
            default:                  phase_nx = LOAD_IN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= LOAD_IN;
            first <= 1'b1;
            r_q <= '0; c_q <= '0; kr_q <= '0; kc_q <= '0;
            row <= '0; col <= '0; i <= '0; j <= '0; ka <= '0; kb <= '0;
            pos <= '0;
            bus.outMatrix <= '0;
        end else begin
            phase <= phase_nx;
            first <= (phase_nx == LOAD_IN) && (phase != LOAD_IN);
            if (first) begin
                r_q  <= bus.inRow;
                c_q  <= bus.inCol;
                kr_q <= bus.kerRow;
                kc_q <= bus.kerCol;
            end
            case (phase)
                LOAD_IN: begin
                    if (row_end) begin
                        col <= '0;
                        row <= load_in_end ? '0 : row + 4'd1;
                    end else begin
                        col <= col + 4'd1;
                    end
                end
                LOAD_K: begin
                    if (col == kc_q) begin
                        col <= '0;
                        row <= load_k_end ? '0 : row + 4'd1;
                    end else begin
                        col <= col + 4'd1;
                    end
                end
                GAP: begin
                    col <= gap_end ? '0 : col + 4'd1;
                    i <= '0; j <= '0; ka <= '0; kb <= '0;
                    pos <= '0;
                end
                COMPUTE: begin
                    if (k_row_end) begin
                        kb <= '0;
                        if (pos_end) begin
                            ka  <= '0;
                            pos <= comp_end ? '0 : pos + 1'b1;
                            if (j == co - 4'd1) begin
                                j <= '0;
                                i <= i + 4'd1;
                            end else begin
                                j <= j + 4'd1;
                            end
                        end else begin
                            ka <= ka + 4'd1;
                        end
                    end else begin
                        kb <= kb + 4'd1;
                    end
                end
                OUT: begin
                    bus.outMatrix <= res_buf[pos];
                    pos <= out_end ? '0 : pos + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Buffers carry no reset; their contents are don't-care until reloaded.
    always_ff @(posedge clk) begin
        if (wr_in) in_buf[wr_in_addr] <= bus.inMatrix;
        if (wr_k)  k_buf[wr_k_addr]   <= bus.kernel;
        if ((phase == COMPUTE) && pos_end) res_buf[pos] <= acc;
    end

    conv_mac #(
        .DW(DW),
        .OW(OW)
    ) u_mac (
        .clk(clk),
        .rst(rst),
        .clr(mac_clr),
        .en (mac_en),
        .a  (mac_a),
        .b  (mac_b),
        .acc(acc)
    );

endmodule

// File: tb/tb_conv_2d.sv
// Frame-level bench for conv_2d: drives whole load/compute/output periods and
// compares every output edge against a direct sum-of-products model.
module tb_conv_2d;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    int   edge_no = 0;
    logic [OW-1:0] last_out = '0;
    int   m  [16][16];
    int   kk [16][16];
    int   y  [64];

    conv_2d_if bus ();

    conv_2d dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s edge %0d: got %0d, expected %0d", tag, edge_no, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_no++;
    endtask

    task automatic scramble_dims();
        bus.inRow  = 4'($urandom);
        bus.inCol  = 4'($urandom);
        bus.kerRow = 4'($urandom);
        bus.kerCol = 4'($urandom);
    endtask

    task automatic load_spec();
        for (int a = 0; a < 5; a++)
            for (int b = 0; b < 5; b++)
                m[a][b] = a * 5 + b;
        m[0][0] = 1;
        m[0][1] = 0;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                kk[a][b] = ((a + b) % 2 == 0) ? 1 : 0;
    endtask

    task automatic randomize_data(input bit saturate);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                m[a][b]  = saturate ? 255 : int'($urandom_range(0, 255));
                kk[a][b] = saturate ? 255 : int'($urandom_range(0, 255));
            end
    endtask

    // abort_at >= 0 asserts reset at that COMPUTE beat; first_rel > 0 checks the
    // edge count from frame start to the first result.
    task automatic run_frame(input int r, input int c, input int kr, input int kc,
                             input logic [7:0] gapv, input int abort_at, input int first_rel);
        int e0, ro, co, s;
        bit legal, first;
        e0 = edge_no;
        first = 1'b1;
        legal = (kr > 0) && (kc > 0) && (kr <= r) && (kc <= c)
             && (r <= MAX_IN) && (c <= MAX_IN) && (kr <= MAX_K) && (kc <= MAX_K);
        bus.inRow  = 4'(r);
        bus.inCol  = 4'(c);
        bus.kerRow = 4'(kr);
        bus.kerCol = 4'(kc);
        for (int rr = 0; rr < r; rr++)
            for (int cc = 0; cc <= c; cc++) begin
                bus.inMatrix = (cc < c) ? 8'(m[rr][cc]) : gapv;
                bus.kernel   = 8'($urandom);
                step();
                if (first) begin
                    scramble_dims();
                    first = 1'b0;
                end
                check("hold_load_in", bus.outMatrix, last_out);
            end
        for (int rr = 0; rr < kr; rr++)
            for (int cc = 0; cc <= kc; cc++) begin
                bus.kernel   = (cc < kc) ? 8'(kk[rr][cc]) : gapv;
                bus.inMatrix = 8'($urandom);
                step();
                check("hold_load_k", bus.outMatrix, last_out);
            end
        repeat (2) begin
            step();
            check("hold_gap", bus.outMatrix, last_out);
        end
        if (!legal) return;

        ro = r - kr + 1;
        co = c - kc + 1;
        for (int oi = 0; oi < ro; oi++)
            for (int oj = 0; oj < co; oj++) begin
                s = 0;
                for (int a = 0; a < kr; a++)
                    for (int b = 0; b < kc; b++)
                        s += m[oi + a][oj + b] * kk[a][b];
                y[oi * co + oj] = s & 32'hFFFF;
            end

        for (int n = 0; n < ro * co * kr * (kc + 1); n++) begin
            if (n == abort_at) begin
                rst = 1'b1;
                #1;
                check("rst_async", bus.outMatrix, 0);
                step();
                step();
                check("rst_held", bus.outMatrix, 0);
                rst = 1'b0;
                edge_no = 0;
                last_out = '0;
                return;
            end
            step();
            check("hold_compute", bus.outMatrix, last_out);
        end
        for (int p = 0; p < ro * co; p++) begin
            step();
            if (p == 0 && first_rel > 0) check("first_out_edge", edge_no - e0, first_rel);
            check("out", bus.outMatrix, y[p]);
            last_out = OW'(y[p]);
        end
    endtask

    initial begin
        int r, c, kr, kc, mode;
        bus.inMatrix = '0;
        bus.kernel   = '0;
        bus.inRow    = '0;
        bus.inCol    = '0;
        bus.kerRow   = '0;
        bus.kerCol   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", bus.outMatrix, 0);
        rst = 1'b0;
        edge_no = 0;

        load_spec();
        run_frame(5, 5, 3, 3, 8'h00, -1, 153);
        run_frame(5, 5, 3, 3, 8'h00, -1, 153);
        run_frame(5, 5, 3, 3, 8'hFF, -1, 153);

        randomize_data(1'b0);
        run_frame(3, 3, 4, 2, 8'h00, -1, 0);
        load_spec();
        run_frame(5, 5, 3, 3, 8'h00, -1, 153);

        run_frame(5, 5, 3, 3, 8'h00, 50, 0);
        run_frame(5, 5, 3, 3, 8'h00, -1, 153);

        randomize_data(1'b1);
        run_frame(4, 4, 4, 4, 8'h00, -1, 63);
        check("overflow", bus.outMatrix, 57360);

        for (int t = 0; t < 16; t++) begin
            randomize_data($urandom_range(0, 7) == 0);
            mode = (t % 4 == 3) ? int'($urandom_range(1, 3)) : 0;
            r  = $urandom_range(1, 8);
            c  = $urandom_range(1, 8);
            kr = $urandom_range(1, (r < 4) ? r : 4);
            kc = $urandom_range(1, (c < 4) ? c : 4);
            case (mode)
                1: begin
                    r  = $urandom_range(1, 3);
                    kr = r + 1;
                end
                2: kc = 0;
                3: r = $urandom_range(9, 15);
                default: ;
            endcase
            run_frame(r, c, kr, kc, 8'($urandom), -1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conv_2d.md
# conv_2d

Streaming 2-D valid-mode correlation engine. It loads an input matrix and a kernel one byte per clock over narrow data ports, then computes every valid output position as a sum of products. It streams the results out one word per clock, then returns to loading the next matrix/kernel pair. It is a self-sequenced datapath block with no handshake: all phase boundaries follow from the dimension inputs.

## Interface
- `DW`, default 8: input and kernel element width, unsigned.
- `OW`, default 16: result width, unsigned.
- `MAX_IN`, default 8: maximum input rows and columns.
- `MAX_K`, default 4: maximum kernel rows and columns.
- `clk` input, 1 bit: clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `inMatrix` input, DW bits: input matrix element stream.
- `inRow` input, 4 bits: input row count R.
- `inCol` input, 4 bits: input column count C.
- `kernel` input, DW bits: kernel element stream.
- `kerRow` input, 4 bits: kernel row count KR.
- `kerCol` input, 4 bits: kernel column count KC.
- `outMatrix` output, OW bits: result stream.

## Operation
- Phases run in the order LOAD_IN → LOAD_K → GAP → COMPUTE → OUT → LOAD_IN, repeating indefinitely.
- R, C, KR and KC are latched on the first edge of each LOAD_IN. Changes mid-sequence have no effect until the next LOAD_IN.
- **LOAD_IN**, R·(C+1) edges:
  - Samples `inMatrix` row-major.
  - Each row takes C+1 beats. Beats 0..C-1 are stored; beat C is a gap beat and is discarded.
- **LOAD_K**, KR·(KC+1) edges: same scheme on `kernel`; beat KC of each row is discarded.
- **GAP**: 2 idle edges.
- **COMPUTE**, Ro·Co·KR·(KC+1) edges, where Ro=R-KR+1 and Co=C-KC+1:
  - One multiply-accumulate per beat, ordered by output position, then kernel row, then kernel column.
  - One idle beat per kernel row.
  - Result y[i][j] = Σ in[i+a][j+b]·k[a][b] (no kernel flip).
- **OUT**, Ro·Co edges: one stored result per edge, row-major.
- Arithmetic is unsigned. Products and sums wrap modulo 2^OW.
- Illegal dimensions: KR=0, KC=0, KR>R, KC>C, R>MAX_IN, C>MAX_IN, KR>MAX_K or KC>MAX_K.
  - COMPUTE and OUT have zero length; the block goes straight from GAP to LOAD_IN.
  - `outMatrix` holds its value.
- Reset, asserted at any time:
  - State goes to LOAD_IN at beat 0 immediately.
  - `outMatrix` goes to 0.
  - Stored data is don't-care.
  - The beat count restarts on the first rising edge after `rst` falls.

## Timing
- Beat n of a phase is the n-th rising edge within that phase.
- Inputs must be stable at the sampling edge, so the driver updates them away from the edge.
- `outMatrix` updates on OUT edge k to the result for position k. It holds that value until the next OUT edge.
- After OUT it keeps the last result until the next OUT phase or reset.
- Total period = R(C+1) + KR(KC+1) + 2 + Ro·Co·KR(KC+1) + Ro·Co edges. With R=C=5 and KR=KC=3 this is 30+12+2+108+9 = 161.
- There is no backpressure and no valid strobe; the consumer tracks phase by counting edges.

## Structure
- Shared package `conv_pkg` holds:
  - DW, OW, MAX_IN and MAX_K.
  - The phase enum (LOAD_IN, LOAD_K, GAP, COMPUTE, OUT).
  - The 4-bit dimension type.
- Top level contains:
  - The phase FSM with nested row/column/kernel counters.
  - An input buffer of MAX_IN×MAX_IN×DW bits.
  - A kernel buffer of MAX_K×MAX_K×DW bits.
  - A result buffer of (MAX_IN)²×OW bits.
- One sub-module, `conv_mac`: DW×DW multiply into an OW-bit accumulator, with clear and enable inputs.

## Test plan
- **Spec example:**
  - Input, R=C=5: rows [1 0 2 3 4], [5..9], [10..14], [15..19], [20..24], each followed by a gap byte 0.
  - Kernel, KR=KC=3: [[1,0,1],[0,1,0],[1,0,1]], each row followed by a gap byte 0.
  - Required OUT stream: 31 34 40 55 60 65 80 85 90.
  - The first output appears at edge 153 after reset.
- **Back-to-back:** rerun the same stimulus in the next 161-edge period → the identical nine values.
- **Gap beats ignored:** drive 0xFF on every gap beat → the output is unchanged from the spec example.
- **Overflow:**
  - R=C=4, KR=KC=4, all elements 0xFF → a single result 16·65025 mod 65536 = 57360.
  - OUT starts after 20+20+2+20 edges.
- **Reset mid-COMPUTE:**
  - Required response: `outMatrix`=0 immediately.
  - A full reload after reset then yields the correct spec-example values.
- **Illegal dimensions:** KR=4 with R=3 → no OUT phase, `outMatrix` holds, and the next LOAD_IN starts right after GAP.
